// File: rtl/mul_pkg.sv
// Shared types and width helpers for the multiply-accumulate sequencer.
package mul_pkg;

    localparam int DEF_BITWIDTH_INPUT = 64;
    localparam int PROD_BITWIDTH      = 2 * DEF_BITWIDTH_INPUT;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } mul_state_e;

    function automatic int prod_bw(input int bw);
        return 2 * bw;
    endfunction

    // Eight guard bits allow 256 full-scale products before the accumulator wraps.
    function automatic int acc_bw_default(input int bw);
        return prod_bw(bw) + 8;
    endfunction

endpackage

// File: rtl/mul_valid_delay.sv
// Shift register carrying {valid,last} alongside the products in the multiplier pipeline.
module mul_valid_delay #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic in_vld,
    input  logic in_last,
    output logic out_vld,
    output logic out_last
);

    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] vld_d;
    logic [DEPTH-1:0] last_q;
    logic [DEPTH-1:0] last_d;

    // Shift one stage per cycle; stage 0 takes the new entry.
    always_comb begin
        vld_d     = vld_q;
        last_d    = last_q;
        vld_d[0]  = in_vld;
        last_d[0] = in_last;
        for (int i = 1; i < DEPTH; i++) begin
            vld_d[i]  = vld_q[i-1];
            last_d[i] = last_q[i-1];
        end
    end

    // Delay line state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q  <= {DEPTH{1'b0}};
            last_q <= {DEPTH{1'b0}};
        end else begin
            vld_q  <= vld_d;
            last_q <= last_d;
        end
    end

    assign out_vld  = vld_q[DEPTH-1];
    assign out_last = last_q[DEPTH-1];

endmodule

// File: rtl/mul_acc_sequencer.sv
// Streams operand pairs into an external pipelined multiplier and accumulates its
// products, presenting one result per stream on a valid/ready output.
module mul_acc_sequencer
    import mul_pkg::*;
#(
    parameter int BITWIDTH_INPUT = DEF_BITWIDTH_INPUT,
    parameter int MUL_LATENCY    = 4,
    parameter int ACC_BITWIDTH   = acc_bw_default(BITWIDTH_INPUT),
    parameter int CNT_BITWIDTH   = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [BITWIDTH_INPUT-1:0]     s_a,
    input  logic [BITWIDTH_INPUT-1:0]     s_b,
    input  logic                          s_last,
    output logic [BITWIDTH_INPUT-1:0]     mul_a,
    output logic [BITWIDTH_INPUT-1:0]     mul_b,
    input  logic [2*BITWIDTH_INPUT-1:0]   mul_q,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [ACC_BITWIDTH-1:0]       m_acc,
    output logic                          m_overflow,
    output logic [CNT_BITWIDTH-1:0]       m_count
);

    localparam int PROD_W = prod_bw(BITWIDTH_INPUT);
    localparam logic [CNT_BITWIDTH-1:0] CNT_ONE = {{(CNT_BITWIDTH-1){1'b0}}, 1'b1};

    mul_state_e                 state_q, state_d;
    logic [BITWIDTH_INPUT-1:0]  mul_a_q, mul_a_d;
    logic [BITWIDTH_INPUT-1:0]  mul_b_q, mul_b_d;
    logic                       pair_vld_q, pair_vld_d;
    logic                       pair_last_q, pair_last_d;
    logic [ACC_BITWIDTH-1:0]    acc_q, acc_d;
    logic                       ovf_q, ovf_d;
    logic [CNT_BITWIDTH-1:0]    cnt_q, cnt_d;
    logic                       m_valid_q, m_valid_d;
    logic [ACC_BITWIDTH-1:0]    m_acc_q, m_acc_d;
    logic                       m_ovf_q, m_ovf_d;
    logic [CNT_BITWIDTH-1:0]    m_count_q, m_count_d;

    logic                       accept_s;
    logic                       tail_vld_s;
    logic                       tail_last_s;
    logic [ACC_BITWIDTH:0]      sum_s;
    logic                       ovf_next_s;
    logic [CNT_BITWIDTH-1:0]    cnt_next_s;

    assign s_ready  = (state_q == ACCUM) && !rst;
    assign accept_s = s_valid && s_ready;

    // The pair flag is registered with mul_a/mul_b, so the delay line only has to
    // cover the multiplier's own latency to line up with mul_q.
    mul_valid_delay #(
        .DEPTH (MUL_LATENCY)
    ) u_delay (
        .clk      (clk),
        .rst      (rst),
        .in_vld   (pair_vld_q),
        .in_last  (pair_last_q),
        .out_vld  (tail_vld_s),
        .out_last (tail_last_s)
    );

    // Accumulator arithmetic with carry capture and saturating product count.
    always_comb begin
        sum_s      = {1'b0, acc_q} + {{(ACC_BITWIDTH + 1 - PROD_W){1'b0}}, mul_q};
        ovf_next_s = ovf_q | sum_s[ACC_BITWIDTH];
        if (cnt_q == {CNT_BITWIDTH{1'b1}}) begin
            cnt_next_s = cnt_q;
        end else begin
            cnt_next_s = cnt_q + CNT_ONE;
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_d     = state_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        pair_vld_d  = accept_s;
        pair_last_d = accept_s && s_last;
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        cnt_d       = cnt_q;
        m_valid_d   = m_valid_q;
        m_acc_d     = m_acc_q;
        m_ovf_d     = m_ovf_q;
        m_count_d   = m_count_q;

        if (accept_s) begin
            mul_a_d = s_a;
            mul_b_d = s_b;
        end else begin
            mul_a_d = mul_a_q;
        end

        if (tail_vld_s) begin
            acc_d = sum_s[ACC_BITWIDTH-1:0];
            ovf_d = ovf_next_s;
            cnt_d = cnt_next_s;
        end else begin
            acc_d = acc_q;
        end

        case (state_q)
            ACCUM: begin
                if (accept_s && s_last) begin
                    state_d = DRAIN;
                end else begin
                    state_d = ACCUM;
                end
            end
            DRAIN: begin
                if (tail_vld_s && tail_last_s) begin
                    m_acc_d   = sum_s[ACC_BITWIDTH-1:0];
                    m_ovf_d   = ovf_next_s;
                    m_count_d = cnt_next_s;
                    m_valid_d = 1'b1;
                    state_d   = HOLD;
                end else begin
                    state_d = DRAIN;
                end
            end
            HOLD: begin
                if (m_valid_q && m_ready) begin
                    m_valid_d = 1'b0;
                    acc_d     = {ACC_BITWIDTH{1'b0}};
                    ovf_d     = 1'b0;
                    cnt_d     = {CNT_BITWIDTH{1'b0}};
                    state_d   = ACCUM;
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    // State, operand and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ACCUM;
            mul_a_q     <= {BITWIDTH_INPUT{1'b0}};
            mul_b_q     <= {BITWIDTH_INPUT{1'b0}};
            pair_vld_q  <= 1'b0;
            pair_last_q <= 1'b0;
            acc_q       <= {ACC_BITWIDTH{1'b0}};
            ovf_q       <= 1'b0;
            cnt_q       <= {CNT_BITWIDTH{1'b0}};
            m_valid_q   <= 1'b0;
            m_acc_q     <= {ACC_BITWIDTH{1'b0}};
            m_ovf_q     <= 1'b0;
            m_count_q   <= {CNT_BITWIDTH{1'b0}};
        end else begin
            state_q     <= state_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            pair_vld_q  <= pair_vld_d;
            pair_last_q <= pair_last_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            cnt_q       <= cnt_d;
            m_valid_q   <= m_valid_d;
            m_acc_q     <= m_acc_d;
            m_ovf_q     <= m_ovf_d;
            m_count_q   <= m_count_d;
        end
    end

    assign mul_a      = mul_a_q;
    assign mul_b      = mul_b_q;
    assign m_valid    = m_valid_q;
    assign m_acc      = m_acc_q;
    assign m_overflow = m_ovf_q;
    assign m_count    = m_count_q;

endmodule

// File: doc/mul_acc_sequencer.md
Name: mul_acc_sequencer

Overview:
Streaming front/back-end for the pipelined unsigned multiplier. Accepts operand pairs over a valid/ready stream and registers them onto the multiplier inputs. It tracks each product through the multiplier's fixed latency and accumulates the returned products. At end of stream it presents one accumulated result on an output valid/ready handshake. It sits directly around the multiplier: drives its a/b, consumes its q.

Parameters:
BITWIDTH_INPUT, 64, operand width; multiplier product is 2*BITWIDTH_INPUT.
MUL_LATENCY, 4, cycles from a/b register update to valid q (must be >=1).
ACC_BITWIDTH, 2*BITWIDTH_INPUT+8, accumulator width (must be >= 2*BITWIDTH_INPUT).
CNT_BITWIDTH, 32, product-count width.

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous reset, active-high
s_valid  in  1  operand pair valid
s_ready  out  1  block can accept operand pair
s_a  in  BITWIDTH_INPUT  operand A
s_b  in  BITWIDTH_INPUT  operand B
s_last  in  1  pair is last of stream
mul_a  out  BITWIDTH_INPUT  registered operand to multiplier a
mul_b  out  BITWIDTH_INPUT  registered operand to multiplier b
mul_q  in  2*BITWIDTH_INPUT  product from multiplier q
m_valid  out  1  result valid
m_ready  in  1  downstream accepts result
m_acc  out  ACC_BITWIDTH  accumulated sum of products
m_overflow  out  1  sticky: accumulator wrapped during this stream
m_count  out  CNT_BITWIDTH  number of products in this stream, saturating

Behaviour:
- Reset (async assert, sync release): state=ACCUM; s_ready=0 while rst high; all outputs 0; valid/last delay line cleared; accumulator, count, overflow = 0. First cycle after release: s_ready=1.
- Accept = s_valid & s_ready. On accept at edge k: mul_a<=s_a, mul_b<=s_b; push {1, s_last} into delay line of depth MUL_LATENCY. Without accept: mul_a/mul_b hold; push {0,0}.
- Delay-line tail valid after edge k+MUL_LATENCY. mul_q is sampled only when tail valid; otherwise ignored.
- On tail valid at edge k+MUL_LATENCY+1: acc<=acc+zero-extended mul_q (modulo 2^ACC_BITWIDTH); carry out sets overflow; count increments, saturates at all-ones.
- States:
  ACCUM: s_ready=1. Accept with s_last -> DRAIN.
  DRAIN: s_ready=0. Wait for tail with last. At that edge the final product is accumulated; m_acc/m_overflow/m_count are loaded with final values; m_valid<=1 -> HOLD.
  HOLD: s_ready=0, m_valid=1, outputs stable. On m_valid&m_ready edge: m_valid<=0; acc, count and overflow cleared; -> ACCUM.
- Latency: single-pair stream accepted at edge k gives m_valid high after edge k+MUL_LATENCY+1.
- Back-to-back accepts at one per cycle are supported in ACCUM; no bubbles required.
- Streams never interleave: the next stream cannot start until the result is accepted. Minimum stream gap is MUL_LATENCY+2 cycles, plus m_ready stall.
- m_valid must not drop, and outputs must not change, until accepted.
- Zero products accumulate normally. A stream of only a last pair gives count=1.
- rst during any state aborts the stream: in-flight products are discarded and the block returns to reset values.

Decomposition:
- Shared package mul_pkg: state enum (ACCUM, DRAIN, HOLD); function for the default ACC_BITWIDTH; localparam PROD_BITWIDTH = 2*BITWIDTH_INPUT.
- One natural sub-module: mul_valid_delay, a MUL_LATENCY-deep shift register of {valid,last} with async active-high reset.
- The multiplier itself is instantiated beside this block at top level, not inside it.

Test Plan:
Bench setup: BITWIDTH_INPUT=64, MUL_LATENCY=4. The bench models the multiplier as a 4-stage registered a*b.
- Single pair a=3, b=5, last=1, m_ready=1 -> m_valid exactly 5 cycles after accept; m_acc=15, m_count=1, m_overflow=0.
- Back-to-back stream: all 256 pairs a,b in 0..15, one per cycle, last on the final pair -> s_ready stays 1 throughout; m_acc=14400, m_count=256.
- Backpressure: m_ready=0 for 10 cycles after m_valid -> m_valid/m_acc stable; s_ready=0; next stream accepted only the cycle after the handshake.
- Overflow with ACC_BITWIDTH=128: two pairs of (2^64-1)*(2^64-1) -> m_overflow=1; m_acc = 2*(2^64-1)^2 mod 2^128.
- Gapped stream: s_valid toggling 1/0, pairs (2,2),(4,4),(6,6 last) -> m_acc=56, m_count=3.
- Reset mid-stream: assert rst for 2 cycles while 3 products are in flight -> all outputs 0 immediately. Next stream (7,7,last) gives m_acc=49, m_count=1.
